gp_req_arbiter: RTL and testbench
=================================

# gp_req_arbiter

Two-requester arbiter for the GP engine's simple request bus (valid / rd0_wr1 / addr / wr_data with ready and rd_valid/rd_data return). It sits between the AHB-slave-side request port (requester 0) and the engine's internal master (requester 1), and the single downstream register/memory target. It grants one transfer at a time using round-robin, tracks the single outstanding read, routes read data back to its owner, and enforces a read-return timeout.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address bus width
- RD_TIMEOUT, 255, maximum cycles spent in RD_WAIT before error completion; 0 disables the timeout
---
- i_clk_ahb  in  1  clock, rising edge
- i_rstn_ahb  in  1  reset, asynchronous, active-low
- i_mX_valid  in  1  requester X (X = 0, 1) has a request
- i_mX_rd0_wr1  in  1  requester X direction: 0 = read, 1 = write
- i_mX_addr  in  ADDR_WIDTH  requester X address
- i_mX_wr_data  in  DATA_WIDTH  requester X write data
- o_mX_ready  out  1  requester X request accepted this cycle (combinational)
- o_mX_rd_valid  out  1  read completion pulse to requester X
- o_mX_rd_data  out  DATA_WIDTH  read data to requester X; 0 when o_mX_rd_valid is low
- o_mX_rd_err  out  1  read timed out; qualifies o_mX_rd_valid
- o_valid  out  1  downstream request valid (registered)
- o_rd0_wr1  out  1  downstream direction
- o_addr  out  ADDR_WIDTH  downstream address
- o_wr_data  out  DATA_WIDTH  downstream write data; 0 for reads
- i_ready  in  1  downstream accepts request
- i_rd_valid  in  1  downstream read data valid
- i_rd_data  in  DATA_WIDTH  downstream read data
- o_busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: no transfer in progress.
  - ISSUE: a request is presented downstream.
  - RD_WAIT: waiting for read data.
- Reset state: IDLE, last_grant = 1 so requester 0 wins the first tie, timeout counter 0. All outputs 0.
- Requester handshake:
  - A requester holds valid and its fields stable until it sees o_mX_ready high at a clock edge.
  - Transfer occurs on the edge where valid && ready.
- IDLE arbitration:
  - Exactly one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - o_mX_ready = (state == IDLE) && grant == X. It is never high for both requesters.
- On accept: capture direction, address and write data (write data forced to 0 for reads) into the output registers. Set owner = X, last_grant = X, o_valid = 1, go to ISSUE.
- ISSUE:
  - o_valid and all fields are held stable until i_ready is high at an edge.
  - On that edge, o_valid drops to 0.
  - Write: go to IDLE.
  - Read: go to RD_WAIT and clear the timeout counter.
- RD_WAIT:
  - o_valid = 0. The counter increments each cycle.
  - When i_rd_valid is high: o_owner_rd_valid = 1, o_owner_rd_data = i_rd_data, rd_err = 0 (combinational pass-through). Go to IDLE.
  - When RD_TIMEOUT != 0, counter == RD_TIMEOUT-1 and i_rd_valid is low: pulse o_owner_rd_valid = 1 with rd_err = 1 and rd_data = 0 for one cycle. Go to IDLE.
- Boundary conditions:
  - i_rd_valid on the same cycle as timeout expiry: data wins, no error.
  - i_rd_valid outside RD_WAIT: ignored, routed to no one.
  - Non-owner rd_valid, rd_data and rd_err are always 0.
  - Requester drops valid while not granted: no effect, no state.
  - Reset asserted mid-transfer: immediate return to reset values. Any in-flight downstream transfer is abandoned; a later i_rd_valid is ignored.
- Counter width: $clog2(RD_TIMEOUT+1) bits, minimum 1 bit. It never wraps; it saturates at expiry.

## Timing
- Accept at edge N: o_valid is high from N+1.
- i_ready already high at N+1: downstream transfer at edge N+1; next accept possible at edge N+2.
- Maximum throughput is one transfer per 2 cycles.
- Read completion is seen by the owner in the same cycle as i_rd_valid (zero added latency).
- Error completion asserts RD_TIMEOUT cycles after entering RD_WAIT.
- Arbitration decision is purely combinational in IDLE; no grant is given in ISSUE or RD_WAIT.

## Test plan
- Reset release, no requests: all outputs 0, o_busy 0. m0 write addr 0x10, data 0xA5A5 with i_ready = 1 → o_m0_ready at edge 0; o_valid/o_rd0_wr1 = 1/addr 0x10/wr_data 0xA5A5 for exactly 1 cycle; IDLE after.
- Both valid continuously, writes 0x100 (m0) and 0x200 (m1), i_ready = 1 → grants alternate m0, m1, m0, m1, one every 2 cycles; o_addr alternates 0x100 / 0x200.
- m1 read 0x40, i_ready low for 3 cycles then high, i_rd_valid with 0xDEADBEEF 2 cycles later → o_valid held 4 cycles with fields stable; o_m1_rd_valid = 1 with 0xDEADBEEF; o_m0_rd_valid = 0 throughout; m0 is not granted until IDLE.
- RD_TIMEOUT = 8, m0 read, no i_rd_valid → o_m0_rd_valid = 1 and o_m0_rd_err = 1 with data 0 exactly 8 cycles after entering RD_WAIT. A later i_rd_valid is ignored.
- i_rd_valid on the expiry cycle with data 0x1234 → rd_err = 0, data 0x1234, single pulse.
- Reset asserted during ISSUE and again during RD_WAIT → all outputs 0 immediately; after release, m0 wins a tie against m1.

Source files
------------

// File: rtl/gp_req_arbiter.sv
// gp_req_arbiter: round-robin arbiter for the two GP-engine request ports
// feeding one register/memory target, with read routing and timeout.
module gp_req_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_TIMEOUT = 255
) (
   input  logic                  i_clk_ahb,
   input  logic                  i_rstn_ahb,
   input  logic                  i_m0_valid,
   input  logic                  i_m0_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_m0_addr,
   input  logic [DATA_WIDTH-1:0] i_m0_wr_data,
   output logic                  o_m0_ready,
   output logic                  o_m0_rd_valid,
   output logic [DATA_WIDTH-1:0] o_m0_rd_data,
   output logic                  o_m0_rd_err,
   input  logic                  i_m1_valid,
   input  logic                  i_m1_rd0_wr1,
   input  logic [ADDR_WIDTH-1:0] i_m1_addr,
   input  logic [DATA_WIDTH-1:0] i_m1_wr_data,
   output logic                  o_m1_ready,
   output logic                  o_m1_rd_valid,
   output logic [DATA_WIDTH-1:0] o_m1_rd_data,
   output logic                  o_m1_rd_err,
   output logic                  o_valid,
   output logic                  o_rd0_wr1,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   input  logic                  i_ready,
   input  logic                  i_rd_valid,
   input  logic [DATA_WIDTH-1:0] i_rd_data,
   output logic                  o_busy
);

   localparam int CW =
      (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
   localparam bit TO_EN = (RD_TIMEOUT != 0);
   localparam logic [CW-1:0] CNT_LAST =
      CW'((RD_TIMEOUT > 0) ? RD_TIMEOUT - 1 : 0);
   localparam logic [CW-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_WAIT
   } state_t;

   state_t          state;
   logic            last_grant;
   logic            owner;
   logic [CW-1:0]   rd_cnt;

   logic            gnt0;
   logic            gnt1;
   logic            accept;
   logic            sel1;
   logic            acc_wr;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [DATA_WIDTH-1:0] acc_data;
   logic            rd_hit;
   logic            rd_to;
   logic            rd_done;

   // Round-robin pick: a lone requester wins, a tie goes to the
   // requester that was not granted last.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (i_m0_valid && i_m1_valid) begin
         gnt0 = last_grant;
         gnt1 = !last_grant;
      end else begin
         gnt0 = i_m0_valid;
         gnt1 = i_m1_valid;
      end
   end

   assign o_m0_ready = (state == IDLE) && gnt0;
   assign o_m1_ready = (state == IDLE) && gnt1;
   assign accept     = o_m0_ready || o_m1_ready;
   assign sel1       = o_m1_ready;

   // Mux the winning requester's fields; reads carry no write data.
   always_comb begin
      acc_wr   = sel1 ? i_m1_rd0_wr1 : i_m0_rd0_wr1;
      acc_addr = sel1 ? i_m1_addr : i_m0_addr;
      acc_data = '0;
      if (acc_wr) begin
         acc_data = sel1 ? i_m1_wr_data : i_m0_wr_data;
      end
   end

   // Read completion: data always beats an expiring timeout.
   always_comb begin
      rd_hit  = (state == RD_WAIT) && i_rd_valid;
      rd_to   = TO_EN && (state == RD_WAIT) &&
                !i_rd_valid && (rd_cnt == CNT_LAST);
      rd_done = rd_hit || rd_to;
   end

   // Main sequencer: accept, present downstream, wait for read data.
   always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
      if (!i_rstn_ahb) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         rd_cnt     <= '0;
         o_valid    <= 1'b0;
         o_rd0_wr1  <= 1'b0;
         o_addr     <= '0;
         o_wr_data  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  owner      <= sel1;
                  last_grant <= sel1;
                  o_valid    <= 1'b1;
                  o_rd0_wr1  <= acc_wr;
                  o_addr     <= acc_addr;
                  o_wr_data  <= acc_data;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  if (o_rd0_wr1) begin
                     state <= IDLE;
                  end else begin
                     rd_cnt <= '0;
                     state  <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               if (rd_done) begin
                  state <= IDLE;
               end else if (rd_cnt != CNT_MAX) begin
                  rd_cnt <= rd_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Route the completion to the owner only; the other side stays 0.
   always_comb begin
      o_m0_rd_valid = rd_done && !owner;
      o_m1_rd_valid = rd_done && owner;
      o_m0_rd_err   = rd_to && !owner;
      o_m1_rd_err   = rd_to && owner;
      o_m0_rd_data  = '0;
      o_m1_rd_data  = '0;
      if (rd_hit && !owner) begin
         o_m0_rd_data = i_rd_data;
      end
      if (rd_hit && owner) begin
         o_m1_rd_data = i_rd_data;
      end
   end

   assign o_busy = (state != IDLE);

   a_excl_ready : assert property (
      @(posedge i_clk_ahb) disable iff (!i_rstn_ahb)
      !(o_m0_ready && o_m1_ready));

   a_valid_issue : assert property (
      @(posedge i_clk_ahb) disable iff (!i_rstn_ahb)
      o_valid == (state == ISSUE));

   a_excl_rd : assert property (
      @(posedge i_clk_ahb) disable iff (!i_rstn_ahb)
      !(o_m0_rd_valid && o_m1_rd_valid));

endmodule

// File: tb/tb_gp_req_arbiter.sv
// Randomized scoreboard bench for gp_req_arbiter: two random requesters,
// a random downstream target and a transaction-level reference model.
module tb_gp_req_arbiter;

   localparam int DW   = 32;
   localparam int AW   = 32;
   localparam int TMO  = 8;
   localparam int NCYC = 6000;

   typedef struct packed {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } ds_t;

   typedef struct packed {
      logic          own;
      logic          err;
      logic [DW-1:0] data;
   } cpl_t;

   logic clk = 1'b0;
   logic rstn;
   logic v0, w0, v1, w1;
   logic [AW-1:0] a0, a1;
   logic [DW-1:0] d0, d1;
   logic r0, r1, rv0, rv1, re0, re1;
   logic [DW-1:0] rd0, rd1;
   logic ov, ow;
   logic [AW-1:0] oa;
   logic [DW-1:0] od;
   logic ird, irv;
   logic [DW-1:0] irdata;
   logic busy;

   ds_t  ds_q[$];
   cpl_t cpl_q[$];
   bit   mdl_idle = 1'b1;
   bit   mdl_last = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_xfer = 0;
   int   n_cpl = 0;
   int   dut_xfer = 0;
   int   dut_cpl = 0;

   always #5 clk = ~clk;

   gp_req_arbiter #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .RD_TIMEOUT(TMO)
   ) dut (
      .i_clk_ahb    (clk),
      .i_rstn_ahb   (rstn),
      .i_m0_valid   (v0),
      .i_m0_rd0_wr1 (w0),
      .i_m0_addr    (a0),
      .i_m0_wr_data (d0),
      .o_m0_ready   (r0),
      .o_m0_rd_valid(rv0),
      .o_m0_rd_data (rd0),
      .o_m0_rd_err  (re0),
      .i_m1_valid   (v1),
      .i_m1_rd0_wr1 (w1),
      .i_m1_addr    (a1),
      .i_m1_wr_data (d1),
      .o_m1_ready   (r1),
      .o_m1_rd_valid(rv1),
      .o_m1_rd_data (rd1),
      .o_m1_rd_err  (re1),
      .o_valid      (ov),
      .o_rd0_wr1    (ow),
      .o_addr       (oa),
      .o_wr_data    (od),
      .i_ready      (ird),
      .i_rd_valid   (irv),
      .i_rd_data    (irdata),
      .o_busy       (busy)
   );

   task automatic chk(input string name,
                      input logic [159:0] act,
                      input logic [159:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic new_req(output logic v, output logic w,
                          output logic [AW-1:0] a,
                          output logic [DW-1:0] d);
      v = 1'b1;
      w = 1'($urandom_range(0, 1));
      a = $urandom;
      d = $urandom;
   endtask

   // Monitor: compares DUT outputs with the model and the queues.
   always @(negedge clk) begin : monitor
      ds_t  f;
      cpl_t c;
      logic er0, er1;
      logic [67:0] exp_rd;
      er0 = mdl_idle && v0 && (!v1 || mdl_last);
      er1 = mdl_idle && v1 && (!v0 || !mdl_last);
      chk("m0_ready", r0, er0);
      chk("m1_ready", r1, er1);
      chk("busy", busy, !mdl_idle);
      if (!rstn) begin
         chk("reset_ds", {ov, ow, oa, od}, '0);
         chk("reset_rd", {rv0, re0, rd0, rv1, re1, rd1}, '0);
      end else begin
         if (ov && ird) dut_xfer++;
         if (rv0 || rv1) dut_cpl++;
         if (ds_q.size() != 0) begin
            f = ds_q[0];
            chk("o_valid", ov, 1'b1);
            chk("ds_fields", {ow, oa, od}, f);
            if (ird) begin
               f = ds_q.pop_front();
               n_xfer++;
            end
         end else begin
            chk("o_valid_low", ov, 1'b0);
         end
         exp_rd = '0;
         if (cpl_q.size() != 0) begin
            c = cpl_q.pop_front();
            n_cpl++;
            if (c.own) exp_rd[33:0] = {1'b1, c.err, c.data};
            else exp_rd[67:34] = {1'b1, c.err, c.data};
         end
         chk("rd_return", {rv0, re0, rd0, rv1, re1, rd1}, exp_rd);
      end
   end

   // Driver and reference model: random traffic at the transaction level.
   initial begin : driver
      bit   hs0, hs1, ds_fire, rd_hit, to_hit, live;
      bit   iss_act, rd_act, rd_own;
      bit   did_iss_rst, did_rd_rst;
      ds_t  iss;
      cpl_t c;
      int   rd_k, lat, rst_left;
      iss_act = 0; rd_act = 0; rd_own = 0;
      did_iss_rst = 0; did_rd_rst = 0;
      rd_k = 0; lat = 0; rst_left = 0;
      iss = '0;
      rstn = 1'b0;
      v0 = 0; w0 = 0; a0 = '0; d0 = '0;
      v1 = 0; w1 = 0; a1 = '0; d1 = '0;
      ird = 0; irv = 0; irdata = '0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(negedge clk);
         live    = rstn;
         hs0     = live && v0 && r0;
         hs1     = live && v1 && r1;
         ds_fire = live && iss_act && ird;
         rd_hit  = live && rd_act && irv;
         to_hit  = live && rd_act && !irv && rd_k == TMO - 1;
         @(posedge clk);
         #1;
         if (!rstn) begin
            rst_left = rst_left - 1;
            if (rst_left == 0) rstn = 1'b1;
         end else begin
            if (ds_fire) begin
               iss_act = 0;
               if (!iss.wr) begin
                  rd_act = 1;
                  rd_k   = 0;
                  lat    = $urandom_range(0, TMO + 3);
               end
            end else if (rd_act) begin
               if (rd_hit || to_hit) rd_act = 0;
               else rd_k++;
            end
            if (hs0 || hs1) begin
               iss_act  = 1;
               rd_own   = hs1;
               mdl_last = hs1;
               iss.wr   = hs1 ? w1 : w0;
               iss.addr = hs1 ? a1 : a0;
               iss.data = '0;
               if (iss.wr) iss.data = hs1 ? d1 : d0;
               ds_q.push_back(iss);
            end
            if ((!did_iss_rst && iss_act && cyc > 300) ||
                (!did_rd_rst && rd_act && rd_k == 2 && cyc > 700) ||
                $urandom_range(0, 599) == 0) begin
               if (iss_act) did_iss_rst = 1;
               if (rd_act) did_rd_rst = 1;
               rstn     = 1'b0;
               rst_left = 2;
               iss_act  = 0;
               rd_act   = 0;
               mdl_last = 1'b1;
               ds_q.delete();
               cpl_q.delete();
            end
         end
         mdl_idle = !iss_act && !rd_act;
         ird    = ($urandom_range(0, 9) < 6);
         irdata = $urandom;
         irv    = 1'b0;
         if (rstn && rd_act) begin
            if (rd_k == lat) begin
               irv = 1'b1;
               c = '{own: rd_own, err: 1'b0, data: irdata};
               cpl_q.push_back(c);
            end else if (rd_k == TMO - 1) begin
               c = '{own: rd_own, err: 1'b1, data: '0};
               cpl_q.push_back(c);
            end
         end else begin
            irv = ($urandom_range(0, 9) == 0);
         end
         if (hs0 || (v0 && $urandom_range(0, 19) == 0)) v0 = 1'b0;
         if (!v0 && $urandom_range(0, 9) < 5) new_req(v0, w0, a0, d0);
         if (hs1 || (v1 && $urandom_range(0, 19) == 0)) v1 = 1'b0;
         if (!v1 && $urandom_range(0, 9) < 5) new_req(v1, w1, a1, d1);
      end
      @(negedge clk);
      chk("xfer_count", 160'(dut_xfer), 160'(n_xfer));
      chk("cpl_count", 160'(dut_cpl), 160'(n_cpl));
      chk("traffic_seen", n_xfer > 200, 1'b1);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
